// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Loads a program image into the CPU instruction memory from an 8-bit byte
// stream and holds the CPU in reset until the image has been written.
// Image format: 16-bit big-endian word count N, then N 32-bit big-endian
// words. Word k is written to instruction-memory word address k.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      1-cycle pulse, begins a load (honoured in IDLE, DONE, ERR)
//   in_valid   stream byte on in_data is valid
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle
//   mem_we     instruction-memory write enable, 1-cycle pulse per word
//   mem_addr   instruction-memory word address
//   mem_wdata  assembled instruction word
//   cpu_rst    reset to the CPU, low only in DONE
//   busy       load in progress (LEN_HI .. WRITE)
//   done       image fully written (DONE state)
//   error      bad word count (ERR state)
//   word_cnt   words written so far in the current load
//   dbg_state  current FSM state encoding, for observation only
//
// Handshake: a byte moves when in_valid and in_ready are both high at a
// rising clock edge. in_ready is a registered function of the FSM state and
// never depends on in_valid; a source seeing in_ready low must hold its byte.
// Gaps of any length between bytes are legal.
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_cnt,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_WORD   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // Memory depth in words, widened so N == DEPTH compares cleanly even
    // when ADDR_W is 16.
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [31:0]         word_q, word_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [15:0]         word_cnt_q, word_cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                xfer;
    logic [15:0]         len_new;
    logic [31:0]         word_next;
    logic [15:0]         cnt_inc;

    assign xfer      = in_valid & in_ready_q;
    assign len_new   = {len_q[15:8], in_data};
    assign word_next = {word_q[23:0], in_data};
    assign cnt_inc   = word_cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        word_cnt_d  = word_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // start wins over any byte offered here; in_ready is low so
                // nothing is consumed.
                if (start) begin
                    state_d    = S_LEN_HI;
                    word_cnt_d = 16'd0;
                    byte_idx_d = 2'd0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_new;
                    if (len_new == 16'd0 || {16'd0, len_new} > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_WORD;
                        byte_idx_d = 2'd0;
                    end
                end
            end
            S_WORD: begin
                if (xfer) begin
                    // Shifting in from the bottom gives big-endian assembly:
                    // the first byte ends up in bits 31:24.
                    word_d     = word_next;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d     = S_WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        mem_wdata_d = word_next;
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = cnt_inc;
                state_d    = (cnt_inc == len_q) ? S_DONE : S_WORD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state so they
        // line up with the state they describe.
        in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_WORD);
        busy_d     = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_WORD)   || (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        cpu_rst_d  = (state_d != S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= 16'd0;
            word_q      <= 32'd0;
            byte_idx_q  <= 2'd0;
            word_cnt_q  <= 16'd0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            word_cnt_q  <= word_cnt_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign word_cnt  = word_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// Testbench for imem_boot_loader (ADDR_W = 8).
// Stimulus drives inputs 1 time unit after the rising edge; expected memory
// writes go into exp_q and a monitor compares every mem_we pulse on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       word_cnt;
    logic [2:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+31:0] exp_q[$];

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .word_cnt  (word_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
                check("write_data", mem_wdata, e[31:0]);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        for (int i = 0; i < gap; i++) tick();
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_accept: byte 0x%0h not accepted, expected in_ready within 20 cycles", b);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[31:24], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
            t = t << 8;
        end
    endtask

    task automatic send_len(input logic [15:0] n, input int max_gap);
        send_byte(n[15:8], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
        send_byte(n[7:0],  (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    endtask

    // Wait until the loader leaves the busy states.
    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: busy still 1 after 20 cycles, expected 0", name);
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_done(input string name, input logic [15:0] n);
        check({name, "_done"},    32'(done),     32'd1);
        check({name, "_cpu_rst"}, 32'(cpu_rst),  32'd0);
        check({name, "_error"},   32'(error),    32'd0);
        check({name, "_in_rdy"},  32'(in_ready), 32'd0);
        check({name, "_cnt"},     32'(word_cnt), 32'(n));
        check({name, "_pend"},    32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] img [3];

    // ---------------- stimulus ----------------
    initial begin
        img[0] = 32'h20080005;
        img[1] = 32'h2009000A;
        img[2] = 32'h01095020;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // Reset state, during and after reset.
        @(negedge clk);
        check("rst_cpu_rst",  32'(cpu_rst),  32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_error",    32'(error),    32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_cpu_rst",  32'(cpu_rst),  32'd1);
        check("post_rst_in_ready", 32'(in_ready), 32'd0);
        check("post_rst_busy",     32'(busy),     32'd0);
        check("post_rst_cnt",      32'(word_cnt), 32'd0);
        tick();

        // Continuous N=3 load.
        for (int i = 0; i < 3; i++) push_exp(ADDR_W'(i), img[i]);
        pulse_start();
        send_len(16'd3, 0);
        for (int i = 0; i < 3; i++) send_word(img[i], 0);
        wait_idle("load3_wait");
        check_done("load3", 16'd3);

        // Extra bytes offered in DONE are not consumed.
        in_valid = 1'b1; in_data = 8'hEE;
        @(negedge clk);
        check("extra_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        check("extra_done", 32'(done), 32'd1);
        in_valid = 1'b0;

        // Same image with random gaps.
        for (int i = 0; i < 3; i++) push_exp(ADDR_W'(i), img[i]);
        pulse_start();
        send_len(16'd3, 3);
        for (int i = 0; i < 3; i++) send_word(img[i], 3);
        wait_idle("gap_wait");
        check_done("gap", 16'd3);

        // Length errors: 0 and 257 words.
        pulse_start();
        send_len(16'd0, 0);
        @(negedge clk);
        check("len0_error",   32'(error),   32'd1);
        check("len0_cpu_rst", 32'(cpu_rst), 32'd1);
        check("len0_busy",    32'(busy),    32'd0);
        tick();
        pulse_start();
        @(negedge clk);
        check("err_restart_error", 32'(error), 32'd0);
        tick();
        send_len(16'd257, 0);
        @(negedge clk);
        check("len257_error",   32'(error),   32'd1);
        check("len257_cpu_rst", 32'(cpu_rst), 32'd1);
        tick();

        // Full-depth image: 256 words, last at 0xFF.
        for (int i = 0; i < 256; i++) push_exp(ADDR_W'(i), 32'hA5000000 | 32'(i * 3));
        pulse_start();
        send_len(16'd256, 0);
        for (int i = 0; i < 256; i++) send_word(32'hA5000000 | 32'(i * 3), 0);
        wait_idle("len256_wait");
        check_done("len256", 16'd256);
        check("len256_last_addr", 32'(mem_addr), 32'hFF);

        // Reset in the middle of the second word.
        push_exp(8'h00, 32'h11223344);
        pulse_start();
        send_len(16'd2, 0);
        send_word(32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst = 1'b1;
        #1;
        check("midrst_cpu_rst",  32'(cpu_rst),   32'd1);
        check("midrst_in_ready", 32'(in_ready),  32'd0);
        check("midrst_busy",     32'(busy),      32'd0);
        check("midrst_done",     32'(done),      32'd0);
        check("midrst_cnt",      32'(word_cnt),  32'd0);
        check("midrst_addr",     32'(mem_addr),  32'd0);
        check("midrst_wdata",    mem_wdata,      32'd0);
        check("midrst_pend",     32'(exp_q.size()), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        push_exp(8'h00, 32'hCAFEF00D);
        push_exp(8'h01, 32'h0BADBEEF);
        pulse_start();
        send_len(16'd2, 0);
        send_word(32'hCAFEF00D, 0);
        send_word(32'h0BADBEEF, 0);
        wait_idle("after_rst_wait");
        check_done("after_rst", 16'd2);

        // Reload N=1 with a start pulse while busy.
        push_exp(8'h00, 32'h00000000);
        pulse_start();
        @(negedge clk);
        check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        check("reload_busy",    32'(busy),    32'd1);
        check("reload_done",    32'(done),    32'd0);
        tick();
        send_len(16'd1, 0);
        pulse_start();
        @(negedge clk);
        check("busy_start_in_ready", 32'(in_ready), 32'd1);
        tick();
        send_word(32'h00000000, 0);
        wait_idle("reload_wait");
        check_done("reload", 16'd1);

        tick(); tick();
        check("final_pend", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
